// File: rtl/axi_join_cut.sv
// axi_join_cut: joins a slave-side AXI4 port to a master-side AXI4 port, with an optional spill register per channel.
// Latency: 1 cycle per channel with its CutMask bit set, 0 cycles (pure wire) with the bit clear.
// Backpressure: a cut channel accepts while its overflow entry is free; a wired channel passes ready through.
// Optional feature macro AXI_JOIN_CUT_OUTSTANDING_EN adds outstanding-transaction counters and gates idle_o.
//
// Port packing, MSB first (the bench and neighbours must use the same field order):
//   ax   = {id, addr, len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0], region[3:0], user}
//   w    = {data, strb, last, user}
//   b    = {id, resp[1:0], user}
//   r    = {id, data, resp[1:0], last, user}
//   req  = {aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready}
//   resp = {aw_ready, ar_ready, w_ready, b_valid, b, r_valid, r}

// Two-entry spill register: A drives the output, B absorbs one beat of overflow.
// Latency: 1 cycle in to out; sustains one beat per cycle.
// Backpressure: in_ready is low only while B holds a beat, so in_ready is a pure flop output.
module axi_join_cut_spill #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             empty
);
  logic             a_full, b_full;
  logic [Width-1:0] a_data, b_data;
  logic             push, pop;

  assign in_ready  = ~b_full;
  assign out_valid = a_full;
  assign out_data  = a_data;
  assign empty     = ~a_full;   // B never holds a beat while A is empty
  assign push      = in_valid & ~b_full;
  assign pop       = a_full & out_ready;

  // Move beats between input, overflow and output entries, keeping order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_data <= '0;
      b_data <= '0;
    end else if (push && (!a_full || pop)) begin
      a_data <= in_data;
      a_full <= 1'b1;
    end else if (push) begin
      b_data <= in_data;
      b_full <= 1'b1;
    end else if (pop) begin
      if (b_full) begin
        a_data <= b_data;
        b_full <= 1'b0;
      end else begin
        a_full <= 1'b0;
      end
    end
  end
endmodule

module axi_join_cut #(
  parameter int unsigned SlvIdWidth = 4,
  parameter int unsigned MstIdWidth = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned UserWidth  = 1,
  parameter logic [4:0]  CutMask    = 5'b11111,
  localparam int unsigned AxRestW   = AddrWidth + 29 + UserWidth,
  localparam int unsigned WW        = DataWidth + DataWidth / 8 + 1 + UserWidth,
  localparam int unsigned BRestW    = 2 + UserWidth,
  localparam int unsigned RRestW    = DataWidth + 3 + UserWidth,
  localparam int unsigned SlvReqW   = 2 * (SlvIdWidth + AxRestW) + WW + 5,
  localparam int unsigned MstReqW   = 2 * (MstIdWidth + AxRestW) + WW + 5,
  localparam int unsigned SlvRespW  = 5 + (SlvIdWidth + BRestW) + (SlvIdWidth + RRestW),
  localparam int unsigned MstRespW  = 5 + (MstIdWidth + BRestW) + (MstIdWidth + RRestW)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SlvReqW-1:0]  slv_req_i,
  output logic [SlvRespW-1:0] slv_resp_o,
  output logic [MstReqW-1:0]  mst_req_o,
  input  logic [MstRespW-1:0] mst_resp_i,
  output logic                idle_o
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
  ,
  output logic [7:0]          w_outstanding_o,
  output logic [7:0]          r_outstanding_o
`endif
);
  if (SlvIdWidth < 1 || MstIdWidth < SlvIdWidth) begin : g_bad_id_width
    $fatal(1, "axi_join_cut: need 1 <= SlvIdWidth <= MstIdWidth");
  end

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [UserWidth-1:0]  user;
  } slv_ax_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AxRestW-1:0]    rest;
  } mst_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [UserWidth-1:0]  user;
  } slv_b_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [UserWidth-1:0]  user;
  } mst_b_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
    logic [UserWidth-1:0]  user;
  } slv_r_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
    logic [UserWidth-1:0]  user;
  } mst_r_t;

  typedef struct packed {
    slv_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    slv_ax_t ar; logic ar_valid; logic r_ready;
  } slv_req_t;

  typedef struct packed {
    mst_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    mst_ax_t ar; logic ar_valid; logic r_ready;
  } mst_req_t;

  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready;
    logic b_valid; slv_b_t b; logic r_valid; slv_r_t r;
  } slv_resp_t;

  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready;
    logic b_valid; mst_b_t b; logic r_valid; mst_r_t r;
  } mst_resp_t;

  slv_req_t  slv_req;
  slv_resp_t slv_resp;
  mst_req_t  mst_req;
  mst_resp_t mst_resp;

  assign slv_req    = slv_req_i;
  assign mst_resp   = mst_resp_i;
  assign slv_resp_o = slv_resp;
  assign mst_req_o  = mst_req;

  // Responses are narrowed before their spill registers so the storage uses the slave-side ID width.
  slv_b_t b_in;
  slv_r_t r_in;
  assign b_in = {mst_resp.b.id[SlvIdWidth-1:0], mst_resp.b[BRestW-1:0]};
  assign r_in = {mst_resp.r.id[SlvIdWidth-1:0], mst_resp.r[RRestW-1:0]};

  slv_ax_t aw_out, ar_out;
  w_t      w_out;
  slv_b_t  b_out;
  slv_r_t  r_out;
  logic    aw_out_valid, w_out_valid, b_out_valid, ar_out_valid, r_out_valid;
  logic    aw_in_ready, w_in_ready, b_in_ready, ar_in_ready, r_in_ready;
  logic    aw_empty, w_empty, b_empty, ar_empty, r_empty;

  if (CutMask[0]) begin : g_aw_cut
    axi_join_cut_spill #(.Width($bits(slv_ax_t))) i_spill (
      .clk(clk_i), .rst_n(rst_ni),
      .in_valid(slv_req.aw_valid), .in_ready(aw_in_ready), .in_data(slv_req.aw),
      .out_valid(aw_out_valid), .out_ready(mst_resp.aw_ready), .out_data(aw_out), .empty(aw_empty));
  end else begin : g_aw_wire
    assign aw_out_valid = slv_req.aw_valid;
    assign aw_in_ready  = mst_resp.aw_ready;
    assign aw_out       = slv_req.aw;
    assign aw_empty     = 1'b1;
  end

  if (CutMask[1]) begin : g_w_cut
    axi_join_cut_spill #(.Width($bits(w_t))) i_spill (
      .clk(clk_i), .rst_n(rst_ni),
      .in_valid(slv_req.w_valid), .in_ready(w_in_ready), .in_data(slv_req.w),
      .out_valid(w_out_valid), .out_ready(mst_resp.w_ready), .out_data(w_out), .empty(w_empty));
  end else begin : g_w_wire
    assign w_out_valid = slv_req.w_valid;
    assign w_in_ready  = mst_resp.w_ready;
    assign w_out       = slv_req.w;
    assign w_empty     = 1'b1;
  end

  if (CutMask[2]) begin : g_b_cut
    axi_join_cut_spill #(.Width($bits(slv_b_t))) i_spill (
      .clk(clk_i), .rst_n(rst_ni),
      .in_valid(mst_resp.b_valid), .in_ready(b_in_ready), .in_data(b_in),
      .out_valid(b_out_valid), .out_ready(slv_req.b_ready), .out_data(b_out), .empty(b_empty));
  end else begin : g_b_wire
    assign b_out_valid = mst_resp.b_valid;
    assign b_in_ready  = slv_req.b_ready;
    assign b_out       = b_in;
    assign b_empty     = 1'b1;
  end

  if (CutMask[3]) begin : g_ar_cut
    axi_join_cut_spill #(.Width($bits(slv_ax_t))) i_spill (
      .clk(clk_i), .rst_n(rst_ni),
      .in_valid(slv_req.ar_valid), .in_ready(ar_in_ready), .in_data(slv_req.ar),
      .out_valid(ar_out_valid), .out_ready(mst_resp.ar_ready), .out_data(ar_out), .empty(ar_empty));
  end else begin : g_ar_wire
    assign ar_out_valid = slv_req.ar_valid;
    assign ar_in_ready  = mst_resp.ar_ready;
    assign ar_out       = slv_req.ar;
    assign ar_empty     = 1'b1;
  end

  if (CutMask[4]) begin : g_r_cut
    axi_join_cut_spill #(.Width($bits(slv_r_t))) i_spill (
      .clk(clk_i), .rst_n(rst_ni),
      .in_valid(mst_resp.r_valid), .in_ready(r_in_ready), .in_data(r_in),
      .out_valid(r_out_valid), .out_ready(slv_req.r_ready), .out_data(r_out), .empty(r_empty));
  end else begin : g_r_wire
    assign r_out_valid = mst_resp.r_valid;
    assign r_in_ready  = slv_req.r_ready;
    assign r_out       = r_in;
    assign r_empty     = 1'b1;
  end

  // Assemble the master-side request; request IDs are zero-extended here.
  always_comb begin
    mst_req          = '0;
    mst_req.aw       = {MstIdWidth'(aw_out.id), aw_out[AxRestW-1:0]};
    mst_req.aw_valid = aw_out_valid;
    mst_req.w        = w_out;
    mst_req.w_valid  = w_out_valid;
    mst_req.b_ready  = b_in_ready;
    mst_req.ar       = {MstIdWidth'(ar_out.id), ar_out[AxRestW-1:0]};
    mst_req.ar_valid = ar_out_valid;
    mst_req.r_ready  = r_in_ready;
  end

  // Assemble the slave-side response.
  always_comb begin
    slv_resp          = '0;
    slv_resp.aw_ready = aw_in_ready;
    slv_resp.ar_ready = ar_in_ready;
    slv_resp.w_ready  = w_in_ready;
    slv_resp.b_valid  = b_out_valid;
    slv_resp.b        = b_out;
    slv_resp.r_valid  = r_out_valid;
    slv_resp.r        = r_out;
  end

`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
  logic [7:0] w_cnt, r_cnt;

  // Saturating up/down step; simultaneous inc and dec cancel.
  function automatic logic [7:0] cnt_step(input logic [7:0] cnt, input logic inc, input logic dec);
    logic [7:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt != 8'hFF) nxt = cnt + 8'd1;
    if (dec && !inc && cnt != 8'h00) nxt = cnt - 8'd1;
    return nxt;
  endfunction

  // Track transactions outstanding on the master side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_cnt <= 8'd0;
      r_cnt <= 8'd0;
    end else begin
      w_cnt <= cnt_step(w_cnt, aw_out_valid & mst_resp.aw_ready, mst_resp.b_valid & b_in_ready);
      r_cnt <= cnt_step(r_cnt, ar_out_valid & mst_resp.ar_ready,
                        mst_resp.r_valid & r_in_ready & mst_resp.r.last);
    end
  end

  assign w_outstanding_o = w_cnt;
  assign r_outstanding_o = r_cnt;
  assign idle_o = aw_empty & w_empty & b_empty & ar_empty & r_empty & (w_cnt == 8'd0) & (r_cnt == 8'd0);
`else
  assign idle_o = aw_empty & w_empty & b_empty & ar_empty & r_empty;
`endif
endmodule

// File: tb/tb_axi_join_cut.sv
// Directed bench for axi_join_cut: one fully cut instance and one fully wired instance,
// both with 4-bit slave IDs and 6-bit master IDs.
// Counter checks are compiled only when AXI_JOIN_CUT_OUTSTANDING_EN is defined.
module tb_axi_join_cut;
  localparam int SID = 4;
  localparam int MID = 6;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int UW  = 1;

  typedef struct packed {
    logic [SID-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
    logic [3:0] qos; logic [3:0] region; logic [UW-1:0] user;
  } s_ax_t;
  typedef struct packed {
    logic [MID-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
    logic [3:0] qos; logic [3:0] region; logic [UW-1:0] user;
  } m_ax_t;
  typedef struct packed { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; logic [UW-1:0] user; } w_t;
  typedef struct packed { logic [SID-1:0] id; logic [1:0] resp; logic [UW-1:0] user; } s_b_t;
  typedef struct packed { logic [MID-1:0] id; logic [1:0] resp; logic [UW-1:0] user; } m_b_t;
  typedef struct packed { logic [SID-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic [UW-1:0] user; } s_r_t;
  typedef struct packed { logic [MID-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic [UW-1:0] user; } m_r_t;
  typedef struct packed {
    s_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    s_ax_t ar; logic ar_valid; logic r_ready;
  } s_req_t;
  typedef struct packed {
    m_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    m_ax_t ar; logic ar_valid; logic r_ready;
  } m_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; s_b_t b; logic r_valid; s_r_t r;
  } s_resp_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; m_b_t b; logic r_valid; m_r_t r;
  } m_resp_t;

  logic    clk = 1'b0;
  logic    rst_n;
  s_req_t  creq, wreq;
  s_resp_t cresp, wresp;
  m_req_t  cmreq, wmreq;
  m_resp_t cmresp, wmresp;
  logic    cidle, widle;
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
  logic [7:0] cw_out, cr_out, ww_out, wr_out;
`endif

  int checks = 0;
  int errors = 0;
  int tx, rx;
  logic prev_hs;

  always #5 clk = ~clk;

  axi_join_cut #(.SlvIdWidth(SID), .MstIdWidth(MID), .AddrWidth(AW), .DataWidth(DW),
                 .UserWidth(UW), .CutMask(5'b11111)) u_cut (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(creq), .slv_resp_o(cresp),
    .mst_req_o(cmreq), .mst_resp_i(cmresp), .idle_o(cidle)
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
    , .w_outstanding_o(cw_out), .r_outstanding_o(cr_out)
`endif
  );

  axi_join_cut #(.SlvIdWidth(SID), .MstIdWidth(MID), .AddrWidth(AW), .DataWidth(DW),
                 .UserWidth(UW), .CutMask(5'b00000)) u_wire (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(wreq), .slv_resp_o(wresp),
    .mst_req_o(wmreq), .mst_resp_i(wmresp), .idle_o(widle)
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
    , .w_outstanding_o(ww_out), .r_outstanding_o(wr_out)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    creq   = '0;
    cmresp = '0;
    wreq   = '0;
    wmresp = '0;
    creq.b_ready = 1'b1;
    creq.r_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_aw_valid", cmreq.aw_valid, 1'b0);
    chk("rst_w_valid",  cmreq.w_valid,  1'b0);
    chk("rst_ar_valid", cmreq.ar_valid, 1'b0);
    chk("rst_b_valid",  cresp.b_valid,  1'b0);
    chk("rst_r_valid",  cresp.r_valid,  1'b0);
    chk("rst_aw_ready", cresp.aw_ready, 1'b1);
    chk("rst_b_ready",  cmreq.b_ready,  1'b1);
    chk("rst_idle",     cidle,          1'b1);
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
    chk("rst_w_cnt", cw_out, 8'd0);
    chk("rst_r_cnt", cr_out, 8'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // AR widening, one cycle latency, then R narrowing
    @(negedge clk);
    creq.ar.id = 4'hA; creq.ar.addr = 64'h1000; creq.ar_valid = 1'b1;
    #1 chk("ar_same_cycle", cmreq.ar_valid, 1'b0);
    @(negedge clk);
    creq.ar_valid = 1'b0;
    #1;
    chk("ar_out_valid", cmreq.ar_valid, 1'b1);
    chk("ar_out_id",    cmreq.ar.id,    6'h0A);
    chk("ar_out_addr",  cmreq.ar.addr,  64'h1000);
    chk("ar_busy_idle", cidle,          1'b0);
    cmresp.ar_ready = 1'b1;
    @(negedge clk); #1;
    chk("ar_popped", cmreq.ar_valid, 1'b0);
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
    chk("ar_r_cnt", cr_out, 8'd1);
`endif
    cmresp.ar_ready = 1'b0;
    cmresp.r.id = 6'h2A; cmresp.r.data = 64'hDEAD_BEEF_0123_4567; cmresp.r.last = 1'b1;
    cmresp.r_valid = 1'b1;
    @(negedge clk);
    cmresp.r_valid = 1'b0;
    #1;
    chk("r_out_valid", cresp.r_valid, 1'b1);
    chk("r_out_id",    cresp.r.id,    4'hA);
    chk("r_out_data",  cresp.r.data,  64'hDEAD_BEEF_0123_4567);
    @(negedge clk); #1;
    chk("r_popped",   cresp.r_valid, 1'b0);
    chk("ar_r_idle",  cidle,         1'b1);
`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
    chk("r_last_cnt", cr_out, 8'd0);
`endif

    // 16-beat W burst, master W ready low for three cycles
    creq.w.strb = '1;
    tx = 0; rx = 0; prev_hs = 1'b0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (prev_hs) tx++;
      creq.w_valid  = (tx < 16);
      creq.w.data   = 64'(tx);
      creq.w.last   = (tx == 15);
      #1;
      prev_hs = creq.w_valid && cresp.w_ready;
      if (c == 1) chk("w_rdy_one_beat", cresp.w_ready, 1'b1);
      if (c == 2) chk("w_rdy_two_beats", cresp.w_ready, 1'b0);
      if (c == 3) begin
        chk("w_rdy_held_low", cresp.w_ready, 1'b0);
        cmresp.w_ready = 1'b1;
      end
      if (c >= 3) begin
        chk("w_out_valid", cmreq.w_valid, 1'b1);
        chk("w_out_data",  cmreq.w.data,  64'(rx));
        chk("w_out_last",  cmreq.w.last,  (rx == 15));
        rx++;
      end
    end
    @(negedge clk); #1;
    chk("w_drained", cmreq.w_valid, 1'b0);
    chk("w_idle",    cidle,         1'b1);
    cmresp.w_ready = 1'b0;

    // Wired instance: combinational valid, payload and ready
    @(negedge clk);
    wreq.aw.id = 4'h5; wreq.aw.addr = 64'h2000; wreq.aw.len = 8'd3; wreq.aw_valid = 1'b1;
    #1;
    chk("wire_aw_valid", wmreq.aw_valid, 1'b1);
    chk("wire_aw_id",    wmreq.aw.id,    6'h05);
    chk("wire_aw_addr",  wmreq.aw.addr,  64'h2000);
    chk("wire_aw_len",   wmreq.aw.len,   8'd3);
    chk("wire_aw_nrdy",  wresp.aw_ready, 1'b0);
    wmresp.aw_ready = 1'b1;
    #1 chk("wire_aw_rdy", wresp.aw_ready, 1'b1);
    wmresp.b.id = 6'h33; wmresp.b_valid = 1'b1; wreq.b_ready = 1'b1;
    #1;
    chk("wire_b_valid", wresp.b_valid, 1'b1);
    chk("wire_b_id",    wresp.b.id,    4'h3);
    chk("wire_b_ready", wmreq.b_ready, 1'b1);
    @(negedge clk);
    wreq.aw_valid = 1'b0; wmresp.b_valid = 1'b0; wmresp.aw_ready = 1'b0;
    #1 chk("wire_idle", widle, 1'b1);

    // Asynchronous reset while R spill holds two beats
    creq.r_ready = 1'b0;
    cmresp.r.id = 6'h01; cmresp.r.data = 64'h1111; cmresp.r.last = 1'b0; cmresp.r_valid = 1'b1;
    @(negedge clk);
    cmresp.r.data = 64'h2222;
    @(negedge clk);
    cmresp.r_valid = 1'b0;
    #1;
    chk("rfull_valid", cresp.r_valid, 1'b1);
    chk("rfull_data",  cresp.r.data,  64'h1111);
    chk("rfull_ready", cmreq.r_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r_valid", cresp.r_valid, 1'b0);
    chk("arst_r_ready", cmreq.r_ready, 1'b1);
    chk("arst_idle",    cidle,         1'b1);
    @(negedge clk);
    rst_n = 1'b1; creq.r_ready = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_r_valid", cresp.r_valid, 1'b0);

`ifdef AXI_JOIN_CUT_OUTSTANDING_EN
    // Write outstanding counter
    creq.aw.id = 4'h3; creq.aw_valid = 1'b1; cmresp.aw_ready = 1'b1;
    repeat (3) @(negedge clk);
    creq.aw_valid = 1'b0;
    @(negedge clk); #1;
    chk("cnt_3_aw", cw_out, 8'd3);
    cmresp.b.id = 6'h03; cmresp.b_valid = 1'b1;
    @(negedge clk);
    cmresp.b_valid = 1'b0;
    #1;
    chk("cnt_after_b", cw_out, 8'd2);
    chk("cnt_idle",    cidle,  1'b0);
    creq.aw_valid = 1'b1;
    @(negedge clk);
    creq.aw_valid = 1'b0; cmresp.b_valid = 1'b1;
    @(negedge clk);
    cmresp.b_valid = 1'b0;
    #1 chk("cnt_inc_dec", cw_out, 8'd2);
    creq.aw_valid = 1'b1;
    repeat (300) @(negedge clk);
    creq.aw_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("cnt_saturate", cw_out, 8'd255);
    cmresp.b_valid = 1'b1;
    @(negedge clk);
    cmresp.b_valid = 1'b0;
    @(negedge clk); #1;
    chk("cnt_dec_from_sat", cw_out, 8'd254);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_join_cut.md
Name: axi_join_cut

Overview:
- Parametrised successor to the plain AXI connector. Joins a slave-side AXI4 port to a master-side AXI4 port.
- Each of the five channels (AW, W, B, AR, R) has an independently selectable two-entry spill register, which breaks every combinational valid/ready/payload path on that channel.
- Widens request IDs by zero-extension and narrows response IDs by truncation.
- Sits between crossbar ports and slaves that need timing isolation or a wider ID space.

Parameters:
- SlvIdWidth, 4, ID width on the slave-side port; must be >= 1.
- MstIdWidth, 4, ID width on the master-side port; must be >= SlvIdWidth (elaboration-time fatal otherwise).
- AddrWidth, 64, address width, identical on both sides.
- DataWidth, 64, data width, identical on both sides.
- UserWidth, 1, user width on all channels, identical on both sides.
- CutMask, 5'b11111, one bit per channel (bit0 AW, bit1 W, bit2 B, bit3 AR, bit4 R). 1 = spill register inserted, 0 = pure wire.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_req_i  in  slv_req_t  AXI request from upstream master (SlvIdWidth IDs)
- slv_resp_o  out  slv_resp_t  AXI response to upstream master
- mst_req_o  out  mst_req_t  AXI request to downstream slave (MstIdWidth IDs)
- mst_resp_i  in  mst_resp_t  AXI response from downstream slave
- idle_o  out  1  high when no spill register holds data and no transaction is outstanding (counter present only with feature, see below)

Behaviour:
- ID mapping:
  - AW.id and AR.id out = {(MstIdWidth-SlvIdWidth)'0, id_in}.
  - B.id and R.id back = low SlvIdWidth bits of the master-side id.
  - All other fields are passed unchanged.
- Spill register (per channel with CutMask bit = 1):
  - Two entries, A (output) and B (overflow).
  - in_ready = !B_full.
  - out_valid = A_full.
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - Push with A empty, or A popping the same cycle: data goes to A.
  - Push with A full and not popping: data goes to B.
  - Pop with B full: B moves to A.
  - Simultaneous push and pop with B full cannot occur (in_ready = 0).
  - Latency: 1 cycle minimum in to out. Full throughput: one beat per cycle sustained.
  - Payload and order are preserved exactly; no beat is dropped or duplicated.
  - After out_valid rises, payload is stable until out_ready (AXI rule preserved).
- Wire mode (bit = 0): valid, ready and payload connect combinationally; 0-cycle latency.
- Reset (rst_ni low, asynchronous):
  - All spill entries are empty.
  - All mst_req_o valids = 0 and all slv_resp_o valids = 0. Registered ready outputs = 1 after reset.
  - In-flight data is discarded.
  - Reset mid-transaction is the system's responsibility: both neighbours are reset with the block.
- idle_o:
  - Without the feature: high when all spill registers are empty.
  - Reset value 1.
- No reordering between channels. W may arrive before AW on the master side exactly as it did on the slave side.

Optional Feature:
- Macro AXI_JOIN_CUT_OUTSTANDING_EN.
- Defined: adds two 8-bit saturating counters.
  - Write counter: +1 on master-side AW handshake, -1 on master-side B handshake. A simultaneous inc and dec leaves the count unchanged.
  - Read counter: +1 on AR handshake, -1 on R handshake with last = 1.
  - Saturates at 255 with no wrap; holds at 0 on a spurious decrement.
  - idle_o additionally requires both counters = 0.
  - Adds outputs w_outstanding_o [7:0] and r_outstanding_o [7:0]. Reset 0.
- Undefined: no counters, no extra ports; idle_o reflects spill state only.

Test Plan:
- Reset, then idle: all mst_req_o valids = 0 and all slv_resp_o valids = 0; idle_o = 1; with feature, both counters = 0.
- CutMask = 5'b11111, SlvIdWidth = 4, MstIdWidth = 6, AR id 4'hA addr 0x1000 -> mst AR id 6'h0A appears 1 cycle later; R returned with id 6'h2A -> slv R id 4'hA.
- Back-to-back 16-beat W burst with mst W ready held low for 3 cycles -> slv W ready falls after 2 accepted beats; all 16 beats arrive in order with no gaps once ready = 1; 1 beat per cycle.
- CutMask = 5'b00000 -> AW valid and payload appear on mst_req_o in the same cycle; ready combinationally reflected.
- Assert rst_ni low while the R spill register holds 2 beats -> slv R valid = 0 immediately (asynchronous); entries empty after release.
- Feature on: 3 AW handshakes then 1 B -> w_outstanding_o = 2, idle_o = 0. AW and B in the same cycle -> count unchanged. 300 AW without B -> count stays at 255.
